// File: rtl/rv_mem_access_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access sizes and FSM states.
package rv_mem_access_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/rv_store_align.sv
// Combinational lane alignment: byte enables, replicated store data and the
// misaligned/unsupported-funct3 flag for the access presented in IDLE.
module rv_store_align
    import rv_mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        is_store,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        bad
);

    logic legal;
    logic misaligned;

    always_comb begin
        be         = 4'b1111;
        lane_wdata = 32'd0;
        legal      = 1'b0;
        misaligned = 1'b0;

        if (is_store) begin
            legal = (funct3 == LS_B) || (funct3 == LS_H) || (funct3 == LS_W);
        end else begin
            legal = (funct3 == LS_B) || (funct3 == LS_H) || (funct3 == LS_W) ||
                    (funct3 == LS_BU) || (funct3 == LS_HU);
        end

        // Size lives in funct3[1:0] for both signed and unsigned loads.
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be         = 4'b0001 << addr_lo;
                    lane_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be         = 4'b0011 << {addr_lo[1], 1'b0};
                    lane_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    lane_wdata = wdata;
                end
            endcase
        end

        bad = ~legal | misaligned;
    end

endmodule

// File: rtl/rv_mem_access.sv
// MEM-stage load/store unit: issues one data-bus transaction per valid load/store,
// stalls the pipeline until ack or timeout, and returns the raw load word.
module rv_mem_access
    import rv_mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  state;
    logic [7:0]  tmo_cnt;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic        align_bad;
    logic        access_req;
    logic        start;

    rv_store_align u_align (
        .funct3     (i_funct3),
        .addr_lo    (i_addr[1:0]),
        .wdata      (i_wdata),
        .is_store   (i_mem_write),
        .be         (align_be),
        .lane_wdata (align_wdata),
        .bad        (align_bad)
    );

    assign access_req = i_valid & (i_mem_read | i_mem_write);
    assign start      = (state == ST_IDLE) & access_req & ~align_bad;

    // Stall must cover the issue cycle itself, so it is decoded from the inputs.
    always_comb begin
        o_stall      = ~i_reset & (start | (state == ST_REQ));
        o_misaligned = ~i_reset & (state == ST_IDLE) & access_req & align_bad;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            tmo_cnt     <= 8'd0;
            o_fault     <= 1'b0;
            o_rdata     <= 32'd0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 30'd0;
            o_bus_be    <= 4'd0;
            o_bus_wdata <= 32'd0;
        end else begin
            o_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_write;
                        o_bus_addr  <= i_addr[31:2];
                        o_bus_be    <= align_be;
                        o_bus_wdata <= align_wdata;
                        tmo_cnt     <= 8'd0;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (!o_bus_we) begin
                            o_rdata <= i_bus_rdata;
                        end
                        state <= ST_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_bus_req <= 1'b0;
                        o_rdata   <= 32'd0;
                        o_fault   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_access.sv
// Randomized scoreboard bench for rv_mem_access with a short bus timeout.
module tb_rv_mem_access;

    localparam int T = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic        o_stall, o_misaligned, o_fault, o_bus_req, o_bus_we;
    logic [31:0] o_rdata, o_bus_wdata;
    logic [29:0] o_bus_addr;
    logic [3:0]  o_bus_be;

    rv_mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_fault      (o_fault),
        .o_rdata      (o_rdata),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
    } resp_t;

    bus_t        bus_q[$];
    resp_t       resp_q[$];
    bit          mon_off = 1'b1;
    logic [31:0] model_rdata = 32'd0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected bus transactions on each req rise and expected
    // responses in the cycle after req falls.
    initial begin
        bus_t  cur;
        bus_t  exp_bus;
        resp_t exp_resp;
        logic  prev_req;
        prev_req = 1'b0;
        cur = '0;
        forever begin
            @(negedge i_clk);
            if (mon_off) begin
                prev_req = 1'b0;
            end else begin
                if (o_bus_req && !prev_req) begin
                    cur = {o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata};
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", 96'd1, 96'd0);
                    end else begin
                        exp_bus = bus_q.pop_front();
                        check("bus_txn", 96'(cur), 96'(exp_bus));
                    end
                end else if (o_bus_req && prev_req) begin
                    check("bus_hold", 96'({o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata}), 96'(cur));
                end
                if (!o_bus_req && prev_req) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_resp", 96'd1, 96'd0);
                    end else begin
                        exp_resp = resp_q.pop_front();
                        check("resp", 96'({o_fault, o_rdata}), 96'(exp_resp));
                    end
                    check("resp_stall", 96'(o_stall), 96'd0);
                end else begin
                    check("fault_quiet", 96'(o_fault), 96'd0);
                end
                prev_req = o_bus_req;
            end
        end
    end

    function automatic bit model_ok(input bit is_st, input logic [2:0] f3, input logic [31:0] addr);
        int nbytes;
        bit legal;
        legal  = is_st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nbytes = 1 << int'(f3[1:0]);
        return legal && ((addr % nbytes) == 0);
    endfunction

    // Issue one access starting at posedge+1; returns at a later posedge+1 with the DUT idle.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rdv);
        bit    is_st;
        int    nbytes, ackc, stalls, exp_stalls, len;
        bus_t  eb;
        resp_t er;
        is_st       = wr;
        i_valid     = 1'b1;
        i_mem_read  = rd;
        i_mem_write = wr;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
        if (!model_ok(is_st, f3, addr)) begin
            @(negedge i_clk);
            check("misaligned_pulse", 96'(o_misaligned), 96'd1);
            check("misaligned_stall", 96'(o_stall), 96'd0);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            @(negedge i_clk);
            check("misaligned_clear", 96'(o_misaligned), 96'd0);
            check("misaligned_noreq", 96'(o_bus_req), 96'd0);
            @(posedge i_clk); #1;
            return;
        end
        nbytes   = 1 << int'(f3[1:0]);
        eb.we    = is_st;
        eb.addr  = addr[31:2];
        eb.be    = is_st ? 4'(((1 << nbytes) - 1) << (addr % 4)) : 4'hF;
        if (!is_st)           eb.wdata = 32'd0;
        else if (nbytes == 1) eb.wdata = {24'd0, wdata[7:0]} * 32'h01010101;
        else if (nbytes == 2) eb.wdata = {16'd0, wdata[15:0]} * 32'h00010001;
        else                  eb.wdata = wdata;
        ackc     = delay + 1;
        er.fault = (ackc > T);
        er.rdata = er.fault ? 32'd0 : (is_st ? model_rdata : rdv);
        model_rdata = er.rdata;
        bus_q.push_back(eb);
        resp_q.push_back(er);
        exp_stalls = 1 + (er.fault ? T : ackc);
        stalls = 0;
        @(negedge i_clk);
        check("start_nomis", 96'(o_misaligned), 96'd0);
        if (o_stall) stalls++;
        @(posedge i_clk); #1;
        i_valid     = 1'b0;
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        i_addr      = $urandom;
        i_wdata     = $urandom;
        len = ((ackc > T) ? ackc : T) + 2;
        for (int c = 1; c <= len; c++) begin
            i_bus_ack   = (c == ackc);
            i_bus_rdata = (c == ackc) ? rdv : $urandom;
            @(negedge i_clk);
            if (o_stall) stalls++;
            @(posedge i_clk); #1;
        end
        i_bus_ack = 1'b0;
        check("stall_cycles", 96'(stalls), 96'(exp_stalls));
    endtask

    initial begin
        // Reset with a legal load presented: stall must stay forced low.
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h100;
        repeat (2) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("rst_stall", 96'(o_stall), 96'd0);
        check("rst_outputs", 96'({o_bus_req, o_bus_we, o_fault, o_bus_be, o_bus_addr}), 96'd0);
        check("rst_data", 96'({o_rdata, o_bus_wdata}), 96'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0;
        i_reset = 1'b0;
        mon_off = 1'b0;
        @(posedge i_clk); #1;

        access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABBCCDD, 0, 32'h5555_5555);
        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 3, 32'h8001_1234);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0, 0, 32'h0);
        access(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h1234_5678, 0, 32'h0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, T + 1, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, T - 1, 32'hCAFE_F00D);

        // Reset in the middle of a request.
        bus_q.push_back(bus_t'({1'b0, 30'h0000_0020, 4'hF, 32'd0}));
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h80;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0;
        @(negedge i_clk);
        check("pre_rst_req", 96'(o_bus_req), 96'd1);
        mon_off = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        check("mid_rst_stall", 96'(o_stall), 96'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("post_rst_req", 96'({o_bus_req, o_stall, o_fault}), 96'd0);
        check("post_rst_bus", 96'({o_bus_addr, o_bus_be, o_bus_wdata}), 96'd0);
        check("post_rst_rdata", 96'(o_rdata), 96'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        resp_q.delete();
        model_rdata = 32'd0;
        mon_off = 1'b0;
        @(posedge i_clk); #1;

        access(1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'h0000_BEEF, 1, 32'h0);
        access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0102_0304, 0, 32'hFFFF_FFFF);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0023, 32'h0, 0, 32'h1357_9BDF);

        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, T + 1), $urandom);
        end

        check("bus_q_drained", 96'(bus_q.size()), 96'd0);
        check("resp_q_drained", 96'(resp_q.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_mem_access.md
# rv_mem_access

Memory-stage load/store unit that issues data-bus transactions on behalf of the instruction in the MEM stage and stalls the pipeline until the access completes. It is the write-side and request-side counterpart of the writeback stage's load extraction. Stores are lane-aligned here, with byte enables and replicated write data. Loads return the raw 32-bit bus word; byte/halfword selection and sign extension happen downstream in writeback, using the address LSBs.

## Interface
- TIMEOUT_CYCLES, 255: cycles in REQ without `i_bus_ack` before the access is aborted with a fault; range 1..255.

- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  MEM-stage instruction valid
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store; wins if both read and write are set
- i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective address (ALU result)
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  freeze IF..MEM stages this cycle
- o_misaligned  out  1  one-cycle pulse: misaligned or unsupported-funct3 access, no bus cycle issued
- o_fault  out  1  one-cycle pulse: bus timeout
- o_rdata  out  32  raw load word, valid in RESP and held after
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  30  word address [31:2]
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-aligned write data
- i_bus_ack  in  1  transfer complete; for reads, `i_bus_rdata` is valid in the same cycle
- i_bus_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE:** start = i_valid & (i_mem_read | i_mem_write) & legal & aligned.
  - On start: register addr[31:2], be, wdata, we; go to REQ; o_stall=1.
  - Illegal or misaligned: o_misaligned=1 for that cycle, o_stall=0, stay in IDLE, no bus activity.
- **REQ:** o_bus_req=1, o_stall=1.
  - On i_bus_ack: capture o_rdata <= i_bus_rdata (loads only; stores leave o_rdata unchanged); go to RESP.
  - If the timeout counter reaches TIMEOUT_CYCLES: drop req, o_rdata <= 0, pulse o_fault in the RESP cycle, go to RESP.
- **RESP:** o_stall=0, so the pipeline advances at the end of this cycle. Always return to IDLE; i_valid is ignored in this state, which prevents re-issue of the same instruction.
- **Alignment rules:** H requires addr[0]=0; W requires addr[1:0]=00. Stores accept only funct3 000/001/010. Loads accept 000/001/010/100/101.
- **Store lanes:**
  - B: be = 0001 << addr[1:0]; wdata = {4{i_wdata[7:0]}}.
  - H: be = 0011 << {addr[1],1'b0}; wdata = {2{i_wdata[15:0]}}.
  - W: be = 1111; wdata = i_wdata.
- **Loads:** be = 1111, we = 0, o_bus_wdata = 0.
- **Bus rule:** o_bus_addr/be/we/wdata stay constant while o_bus_req=1. i_bus_ack is ignored unless in REQ; a late ack after a timeout or reset is dropped.

## Timing
- Reset values: state IDLE; o_bus_req, o_bus_we, o_misaligned, o_fault, o_stall = 0; o_bus_addr, o_bus_be, o_bus_wdata, o_rdata, timeout counter = 0. o_stall and o_misaligned are forced to 0 while i_reset=1.
- Start in cycle N → o_bus_req high from N+1. Ack in cycle N+k (k≥1) → RESP in N+k+1 → pipeline advances. Minimum 3 cycles per access, with 2 stall cycles.
- Timeout counter clears on entry to REQ and increments each REQ cycle without ack. An abort triggered in cycle N+TIMEOUT_CYCLES puts RESP with o_fault=1 in the next cycle.
- If ack arrives in the same cycle the counter hits the limit, ack wins: no fault.
- Reset mid-access: o_bus_req=0 from the next cycle, and the access is abandoned.

## Structure
- Shared package / rv_defines.vh:
  - funct3 size encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU)
  - FSM state typedef
- Sub-module rv_store_align: combinational funct3/addr/wdata → be, lane wdata, misaligned/illegal flag. The FSM, counter and registers live in rv_mem_access.

## Test plan
- SB addr 0x1003, wdata 0xAABBCCDD, ack on first REQ cycle → one bus cycle: we=1, addr[31:2]=0x400, be=1000, wdata=0xDDDDDDDD; o_stall high exactly 2 cycles.
- LH addr 0x2002, ack after 3 wait cycles with rdata 0x8001_1234 → o_stall high 5 cycles, o_rdata=0x80011234 in RESP, be=1111, we=0.
- LW addr 0x0001 → o_misaligned pulse, o_bus_req stays 0, o_stall 0; same for SW funct3=011 at addr 0x0000.
- Read with TIMEOUT_CYCLES=4 and no ack → req high 4 cycles then low, o_fault pulse 1 cycle, o_rdata=0; a late ack 2 cycles later is ignored, with no state change.
- i_reset asserted during REQ → next cycle req=0 and all outputs at reset values; a subsequent SH to 0x10 issues normally with be=0011.
- Back-to-back store then load, each acked immediately → two distinct bus cycles, with o_bus_req low for at least the RESP and IDLE cycles between them; no duplicate issue.
